cpu_run_ctrl: RTL and testbench

- Run/step/halt sequencer for the single-cycle RISC-V core (sccomp).
- Gates the core through a clock-enable and stops it on a halt PC, a cycle budget, or a host command.
- When the core is stopped, streams the full register file out over a valid/ready port, using the core's reg_sel/reg_data debug read.
- Sits between a host/debug interface and sccomp; replaces the halt/limit logic currently done ad hoc in simulation.

---
 rtl/run_ctrl_pkg.sv | 27 ++
 rtl/run_cycle_counter.sv | 37 +++
 rtl/cpu_run_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the sccomp run/step/halt controller:
// host commands, halt causes and the controller state.
package run_ctrl_pkg;

  localparam logic [1:0] CMD_RUN  = 2'b00;
  localparam logic [1:0] CMD_STEP = 2'b01;
  localparam logic [1:0] CMD_HALT = 2'b10;
  localparam logic [1:0] CMD_DUMP = 2'b11;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_PC    = 2'b01;
  localparam logic [1:0] CAUSE_LIMIT = 2'b10;
  localparam logic [1:0] CAUSE_HOST  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_DUMP = 2'b11
  } run_state_e;

  // States in which the core may retire instructions.
  function automatic logic is_exec_state(input run_state_e st);
    return (st == ST_RUN) || (st == ST_STEP);
  endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating enabled-cycle counter with synchronous clear and a
// compare against the per-run cycle budget.
module run_cycle_counter #(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] SAT_VAL   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_VAL   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Count enabled cycles; clear has priority and the count never wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && (cnt_r != SAT_VAL)) begin
      cnt_r <= cnt_r + ONE_VAL;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt      = cnt_r;
  assign at_limit = (cnt_r == LIMIT_VAL);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for sccomp: gates the core clock-enable and,
// while stopped, streams the register file out over a valid/ready port.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_PC    = 32'hf0000100,
  parameter int          MAX_CYCLES = 1000,
  parameter int          CNT_W      = 16,
  parameter int          NREG       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic [4:0]       reg_sel,
  input  logic [31:0]      reg_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

  run_state_e state_r;
  logic       halted_r;
  logic [1:0] cause_r;
  logic [4:0] idx_r;
  logic       dump_valid_r;

  logic       stop_pc_s;
  logic       stop_lim_s;
  logic       cmd_acc_s;
  logic       cnt_clr_s;
  logic       cpu_en_s;

  assign stop_pc_s = (pc == HALT_PC);
  assign cmd_ready = (state_r == ST_IDLE) || (state_r == ST_RUN);
  assign cmd_acc_s = cmd_valid && cmd_ready;
  assign cnt_clr_s = cmd_acc_s && (state_r == ST_IDLE) && (cmd == CMD_RUN);
  // Combinational so the instruction sitting at HALT_PC never retires.
  assign cpu_en_s  = is_exec_state(state_r) && !stop_pc_s && !stop_lim_s;
  assign cpu_en    = cpu_en_s;

  run_cycle_counter #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cycle_counter (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (cnt_clr_s),
    .en       (cpu_en_s),
    .cnt      (cycle_cnt),
    .at_limit (stop_lim_s)
  );

  // Controller FSM with registered status and dump-beat outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      halted_r     <= 1'b0;
      cause_r      <= CAUSE_NONE;
      idx_r        <= 5'd0;
      dump_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_acc_s) begin
            case (cmd)
              CMD_RUN: begin
                halted_r <= 1'b0;
                cause_r  <= CAUSE_NONE;
                state_r  <= ST_RUN;
              end
              CMD_STEP: begin
                halted_r <= 1'b0;
                cause_r  <= CAUSE_NONE;
                state_r  <= ST_STEP;
              end
              CMD_DUMP: begin
                idx_r        <= 5'd0;
                dump_valid_r <= 1'b1;
                state_r      <= ST_DUMP;
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop_pc_s) begin
            halted_r <= 1'b1;
            cause_r  <= CAUSE_PC;
            state_r  <= ST_IDLE;
          end else if (stop_lim_s) begin
            halted_r <= 1'b1;
            cause_r  <= CAUSE_LIMIT;
            state_r  <= ST_IDLE;
          end else if (cmd_acc_s && (cmd == CMD_HALT)) begin
            halted_r <= 1'b1;
            cause_r  <= CAUSE_HOST;
            state_r  <= ST_IDLE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_STEP: begin
          if (stop_pc_s) begin
            halted_r <= 1'b1;
            cause_r  <= CAUSE_PC;
          end else if (stop_lim_s) begin
            halted_r <= 1'b1;
            cause_r  <= CAUSE_LIMIT;
          end else begin
            halted_r <= halted_r;
          end
          state_r <= ST_IDLE;
        end
        ST_DUMP: begin
          if (dump_ready) begin
            if (idx_r == LAST_IDX) begin
              idx_r        <= 5'd0;
              dump_valid_r <= 1'b0;
              state_r      <= ST_IDLE;
            end else begin
              idx_r <= idx_r + 5'd1;
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          dump_valid_r <= 1'b0;
          idx_r        <= 5'd0;
        end
      endcase
    end
  end

  assign reg_sel    = idx_r;
  assign dump_idx   = idx_r;
  assign dump_valid = dump_valid_r;
  assign halted     = halted_r;
  assign halt_cause = cause_r;

  // Forward the register-file read only while a beat is being offered.
  always_comb begin
    dump_data = 32'd0;
    if (dump_valid_r) begin
      dump_data = reg_data;
    end else begin
      dump_data = 32'd0;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: PC and register-file models,
// dump beats checked from a scoreboard queue.
module tb_cpu_run_ctrl;

  localparam logic [31:0] HALT_PC = 32'hf0000100;
  localparam logic [1:0]  C_RUN  = 2'b00;
  localparam logic [1:0]  C_STEP = 2'b01;
  localparam logic [1:0]  C_HALT = 2'b10;
  localparam logic [1:0]  C_DUMP = 2'b11;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd = 2'b00;
  logic [31:0] pc = 32'd0;
  logic        cpu_en;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [15:0] cycle_cnt;

  logic        pc_set = 1'b0;
  logic [31:0] pc_set_v = 32'd0;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;
  beat_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int en_total = 0;
  int en_start = 0;

  cpu_run_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .pc         (pc),
    .cpu_en     (cpu_en),
    .reg_sel    (reg_sel),
    .reg_data   (reg_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .halted     (halted),
    .halt_cause (halt_cause),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  assign reg_data = {27'd0, reg_sel} * 32'h01010101;

  always @(posedge clk) begin
    if (pc_set) pc <= pc_set_v;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: count enabled cycles and score dump beats against the queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (cpu_en) en_total++;
      if (dump_valid) begin
        check_eq("dump_cpu_en", 64'(cpu_en), 64'd0);
        if (exp_q.size() == 0) begin
          check_eq("dump_extra_beat", 64'd1, 64'd0);
        end else begin
          check_eq("dump_idx", 64'(dump_idx), 64'(exp_q[0].idx));
          check_eq("dump_data", 64'(dump_data), 64'(exp_q[0].data));
          check_eq("dump_reg_sel", 64'(reg_sel), 64'(exp_q[0].idx));
          if (dump_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic set_pc(input logic [31:0] v);
    pc_set_v = v;
    pc_set = 1'b1;
    @(posedge clk);
    #1 pc_set = 1'b0;
  endtask

  // Returns #1 after the edge that accepted the command.
  task automatic send_cmd(input logic [1:0] c);
    @(posedge clk);
    #1 cmd = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_stop(input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (!cpu_en) break;
      n++;
    end
    if (n >= budget) check_eq("stop_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_cpu_en"}, 64'(cpu_en), 64'd0);
    check_eq({tag, "_reg_sel"}, 64'(reg_sel), 64'd0);
    check_eq({tag, "_dump_valid"}, 64'(dump_valid), 64'd0);
    check_eq({tag, "_dump_idx"}, 64'(dump_idx), 64'd0);
    check_eq({tag, "_dump_data"}, 64'(dump_data), 64'd0);
    check_eq({tag, "_halted"}, 64'(halted), 64'd0);
    check_eq({tag, "_cause"}, 64'(halt_cause), 64'd0);
    check_eq({tag, "_cnt"}, 64'(cycle_cnt), 64'd0);
  endtask

  initial begin
    #1 check_reset_vals("por");
    #21 rstn = 1'b1;

    // Reset asserted during RUN cycle 3.
    set_pc(32'd0);
    send_cmd(C_RUN);
    check_eq("run_c1_en", 64'(cpu_en), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_vals("midrun_rst");
    #19 rstn = 1'b1;
    #1 check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // RUN ending on the halt PC after seven instructions.
    set_pc(HALT_PC - 32'd28);
    en_start = en_total;
    send_cmd(C_RUN);
    wait_stop(50);
    check_eq("pc_en_cycles", 64'(en_total - en_start), 64'd7);
    check_eq("pc_halted", 64'(halted), 64'd1);
    check_eq("pc_cause", 64'(halt_cause), 64'd1);
    check_eq("pc_cnt", 64'(cycle_cnt), 64'd7);
    check_eq("pc_pc", 64'(pc), 64'(HALT_PC));

    // RUN ending on the cycle budget.
    set_pc(32'd0);
    en_start = en_total;
    send_cmd(C_RUN);
    wait_stop(1100);
    check_eq("lim_en_cycles", 64'(en_total - en_start), 64'd1000);
    check_eq("lim_halted", 64'(halted), 64'd1);
    check_eq("lim_cause", 64'(halt_cause), 64'd2);
    check_eq("lim_cnt", 64'(cycle_cnt), 64'd1000);

    // New RUN restarts the count; host HALT in cycle 5.
    send_cmd(C_RUN);
    en_start = en_total;
    check_eq("rerun_cnt", 64'(cycle_cnt), 64'd0);
    check_eq("rerun_halted", 64'(halted), 64'd0);
    check_eq("rerun_cause", 64'(halt_cause), 64'd0);
    check_eq("rerun_en", 64'(cpu_en), 64'd1);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1 cmd = C_HALT;
    cmd_valid = 1'b1;
    @(negedge clk);
    check_eq("hhalt_en_in_cycle", 64'(cpu_en), 64'd1);
    check_eq("hhalt_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check_eq("hhalt_en_after", 64'(cpu_en), 64'd0);
    check_eq("hhalt_en_cycles", 64'(en_total - en_start), 64'd5);
    check_eq("hhalt_halted", 64'(halted), 64'd1);
    check_eq("hhalt_cause", 64'(halt_cause), 64'd3);
    check_eq("hhalt_cnt", 64'(cycle_cnt), 64'd5);

    // Three STEPs from reset.
    rstn = 1'b0;
    #10 rstn = 1'b1;
    set_pc(32'h100);
    en_start = en_total;
    for (int s = 0; s < 3; s++) begin
      send_cmd(C_STEP);
      check_eq("step_ready", 64'(cmd_ready), 64'd0);
      check_eq("step_en", 64'(cpu_en), 64'd1);
      @(posedge clk);
      #1 check_eq("step_en_after", 64'(cpu_en), 64'd0);
    end
    check_eq("step_en_cycles", 64'(en_total - en_start), 64'd3);
    check_eq("step_cnt", 64'(cycle_cnt), 64'd3);
    check_eq("step_halted", 64'(halted), 64'd0);

    // Register dump with dump_ready toggling every cycle.
    for (int i = 0; i < 32; i++) begin
      beat_t b;
      b.idx = 5'(i);
      b.data = 32'(i) * 32'h01010101;
      exp_q.push_back(b);
    end
    dump_ready = 1'b0;
    send_cmd(C_DUMP);
    check_eq("dump_ready_low", 64'(cmd_ready), 64'd0);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(posedge clk);
        #1 dump_ready = ~dump_ready;
        n++;
      end
      if (n >= 200) check_eq("dump_timeout", 64'(exp_q.size()), 64'd0);
    end
    dump_ready = 1'b0;
    check_eq("dump_end_valid", 64'(dump_valid), 64'd0);
    check_eq("dump_end_reg_sel", 64'(reg_sel), 64'd0);
    check_eq("dump_end_idx", 64'(dump_idx), 64'd0);
    check_eq("dump_end_ready", 64'(cmd_ready), 64'd1);
    check_eq("dump_end_cnt", 64'(cycle_cnt), 64'd3);
    check_eq("dump_end_halted", 64'(halted), 64'd0);

    // STEP sitting on the halt PC must not execute.
    set_pc(HALT_PC);
    en_start = en_total;
    send_cmd(C_STEP);
    check_eq("step_hpc_en", 64'(cpu_en), 64'd0);
    @(posedge clk);
    #1 check_eq("step_hpc_halted", 64'(halted), 64'd1);
    check_eq("step_hpc_cause", 64'(halt_cause), 64'd1);
    check_eq("step_hpc_cnt", 64'(cycle_cnt), 64'd3);
    check_eq("step_hpc_en_cycles", 64'(en_total - en_start), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
